// File: rtl/spi_slave_shift_if.sv
// Signal bundle for the SPI responder shift engine: SPI pins plus the host-side
// transmit/receive handshake. The slave modport is the engine and the master modport is its driver.
interface spi_slave_shift_if #(
    parameter int DATA_W = 32,
    parameter int LEN_W  = 5
);
    logic              i_sclk;
    logic              i_ss_n;
    logic              i_mosi;
    logic              o_miso;
    logic              o_miso_oe;

    logic [LEN_W-1:0]  i_len;
    logic              i_lsb;
    logic              i_rx_negedge;
    logic              i_tx_negedge;

    logic [DATA_W-1:0] i_tx_data;
    logic              i_tx_valid;
    logic              o_tx_ready;

    logic [DATA_W-1:0] o_rx_data;
    logic              o_rx_valid;
    logic              o_tip;
    logic              o_underrun;
    logic              o_abort;

    modport slave (
        input  i_sclk, i_ss_n, i_mosi, i_len, i_lsb, i_rx_negedge, i_tx_negedge,
        input  i_tx_data, i_tx_valid,
        output o_miso, o_miso_oe, o_tx_ready, o_rx_data, o_rx_valid,
        output o_tip, o_underrun, o_abort
    );

    modport master (
        output i_sclk, i_ss_n, i_mosi, i_len, i_lsb, i_rx_negedge, i_tx_negedge,
        output i_tx_data, i_tx_valid,
        input  o_miso, o_miso_oe, o_tx_ready, o_rx_data, o_rx_valid,
        input  o_tip, o_underrun, o_abort
    );
endinterface

// File: rtl/spi_slave_shift.sv
// SPI responder character engine. It oversamples SCLK/SS_N/MOSI, deserialises MOSI
// into characters, and serialises a one-deep transmit buffer onto MISO.
module spi_slave_shift #(
    parameter int DATA_W = 32,
    parameter int LEN_W  = 5
) (
    input  logic            i_clk,
    input  logic            i_rst_n,
    spi_slave_shift_if.slave bus
);
    localparam int IDX_W = $clog2(DATA_W);
    localparam int CNT_W = IDX_W + 1;

    typedef enum logic [1:0] {IDLE, LOAD, SHIFT} state_t;

    state_t state, state_next;

    logic [2:0]        sclk_q;
    logic [1:0]        ss_q;
    logic [1:0]        mosi_q;
    logic              sclk_rise, sclk_fall, ss_sync, mosi_sync;

    logic [CNT_W-1:0]  len_r, cnt, cnt_after, len_in;
    logic              lsb_r, rx_neg_r, tx_neg_r, rx_seen;
    logic [DATA_W-1:0] tx_sr, tx_buf, rx_sr, rx_word, load_word, rx_data;
    logic              buf_full, miso, miso_oe, tip, rx_valid, underrun, abort;
    logic              rx_edge, tx_edge;
    logic              do_load, do_rx, do_tx, do_done, do_abort, go_idle;

    // Both directions use the same index: after k received bits, MSB-first
    // points at bit len-1-k and LSB-first points at bit k.
    function automatic logic [IDX_W-1:0] bit_pos(input logic lsb,
                                                 input logic [CNT_W-1:0] len,
                                                 input logic [CNT_W-1:0] remaining);
        logic [CNT_W-1:0] p;
        p = lsb ? (len - remaining) : (remaining - CNT_W'(1));
        return p[IDX_W-1:0];
    endfunction

    // MOSI comes from the same synchroniser stage as SCLK, so the data bit lines up with its edge.
    assign sclk_rise = sclk_q[1] & ~sclk_q[2];
    assign sclk_fall = ~sclk_q[1] & sclk_q[2];
    assign ss_sync   = ss_q[1];
    assign mosi_sync = mosi_q[1];

    assign rx_edge   = rx_neg_r ? sclk_fall : sclk_rise;
    assign tx_edge   = tx_neg_r ? sclk_fall : sclk_rise;
    assign len_in    = (bus.i_len == '0) ? CNT_W'(DATA_W) : CNT_W'(bus.i_len);
    assign load_word = buf_full ? tx_buf : '0;
    assign cnt_after = do_rx ? (cnt - CNT_W'(1)) : cnt;

    always_ff @(posedge i_clk) begin
        if (!i_rst_n) state <= IDLE;
        else          state <= state_next;
    end

    // NOTE: every signal is given a default before the case statement, so no
    // path leaves a value unassigned and no latch is inferred.
    always_comb begin
        state_next = state;
        do_load    = 1'b0;
        do_rx      = 1'b0;
        do_tx      = 1'b0;
        do_done    = 1'b0;
        do_abort   = 1'b0;
        go_idle    = 1'b0;
        case (state)
            IDLE:  if (!ss_sync) state_next = LOAD;
            LOAD: begin
                do_load    = 1'b1;
                state_next = SHIFT;
            end
            SHIFT: begin
                if (ss_sync) begin
                    // A deselect before the first bit is simply the end of a
                    // back-to-back chain, not a broken character.
                    do_abort   = rx_seen;
                    go_idle    = 1'b1;
                    state_next = IDLE;
                end else begin
                    if (rx_edge) begin
                        do_rx = 1'b1;
                        if (cnt == CNT_W'(1)) begin
                            do_done    = 1'b1;
                            state_next = LOAD;
                        end
                    end
                    do_tx = tx_edge && rx_seen && !do_done;
                end
            end
            default: state_next = IDLE;
        endcase
    end

    always_comb begin
        rx_word = rx_sr;
        rx_word[bit_pos(lsb_r, len_r, cnt)] = mosi_sync;
    end

    // NOTE: the whole datapath, buffers included, gets a defined reset value.
    // o_rx_data must read zero after reset, and the cost is small at this size.
    always_ff @(posedge i_clk) begin
        if (!i_rst_n) begin
            sclk_q   <= '0;
            ss_q     <= '1;
            mosi_q   <= '0;
            len_r    <= '0;
            cnt      <= '0;
            lsb_r    <= 1'b0;
            rx_neg_r <= 1'b0;
            tx_neg_r <= 1'b0;
            rx_seen  <= 1'b0;
            tx_sr    <= '0;
            tx_buf   <= '0;
            rx_sr    <= '0;
            rx_data  <= '0;
            buf_full <= 1'b0;
            miso     <= 1'b0;
            miso_oe  <= 1'b0;
            tip      <= 1'b0;
            rx_valid <= 1'b0;
            underrun <= 1'b0;
            abort    <= 1'b0;
        end else begin
            // NOTE: registers are written with non-blocking assignments. Every
            // read in this block then sees the value from before the clock edge.
            sclk_q   <= {sclk_q[1:0], bus.i_sclk};
            ss_q     <= {ss_q[0], bus.i_ss_n};
            mosi_q   <= {mosi_q[0], bus.i_mosi};
            rx_valid <= 1'b0;
            underrun <= 1'b0;
            abort    <= 1'b0;

            if (do_load) begin
                len_r    <= len_in;
                cnt      <= len_in;
                lsb_r    <= bus.i_lsb;
                rx_neg_r <= bus.i_rx_negedge;
                tx_neg_r <= bus.i_tx_negedge;
                rx_seen  <= 1'b0;
                rx_sr    <= '0;
                tx_sr    <= load_word;
                miso     <= load_word[bit_pos(bus.i_lsb, len_in, len_in)];
                miso_oe  <= 1'b1;
                tip      <= 1'b1;
                underrun <= ~buf_full;
            end

            if (do_rx) begin
                cnt     <= cnt_after;
                rx_sr   <= rx_word;
                rx_seen <= 1'b1;
                if (do_done) begin
                    rx_data  <= rx_word;
                    rx_valid <= 1'b1;
                end
            end

            if (do_tx) miso <= tx_sr[bit_pos(lsb_r, len_r, cnt_after)];

            if (go_idle) begin
                miso    <= 1'b0;
                miso_oe <= 1'b0;
                tip     <= 1'b0;
                abort   <= do_abort;
            end

            // A load consumes the buffer first. A host write in the same cycle
            // finds ready low and is dropped.
            if (do_load && buf_full) begin
                buf_full <= 1'b0;
            end else if (bus.i_tx_valid && !buf_full) begin
                tx_buf   <= bus.i_tx_data;
                buf_full <= 1'b1;
            end
        end
    end

    assign bus.o_miso     = miso;
    assign bus.o_miso_oe  = miso_oe;
    assign bus.o_tip      = tip;
    assign bus.o_tx_ready = ~buf_full;
    assign bus.o_rx_data  = rx_data;
    assign bus.o_rx_valid = rx_valid;
    assign bus.o_underrun = underrun;
    assign bus.o_abort    = abort;
endmodule

// File: tb/tb_spi_slave_shift.sv
// Directed bench for spi_slave_shift. The bench plays the SPI master with SCLK at
// 1/16 of i_clk, and each task checks its scenario against hand-computed values.
module tb_spi_slave_shift;
    logic clk = 1'b0;
    logic rst_n;
    int   total = 0;
    int   bad   = 0;

    int          rx_pulses = 0;
    int          ur_pulses = 0;
    int          ab_pulses = 0;
    logic [31:0] rx_hist [16];

    spi_slave_shift_if #(.DATA_W(32), .LEN_W(5)) bus ();

    spi_slave_shift #(.DATA_W(32), .LEN_W(5)) dut (
        .i_clk   (clk),
        .i_rst_n (rst_n),
        .bus     (bus)
    );

    always #5 clk = ~clk;

    // A pulse wider than one i_clk is counted more than once, so the pulse counts also check the width.
    always @(negedge clk) begin
        if (rst_n) begin
            if (bus.o_rx_valid) begin
                rx_hist[rx_pulses % 16] = bus.o_rx_data;
                rx_pulses++;
            end
            if (bus.o_underrun) ur_pulses++;
            if (bus.o_abort)    ab_pulses++;
        end
    end

    initial begin
        #1_000_000;
        $display("FAIL watchdog: simulation still running got=timeout required=finish");
        $fatal(1, "watchdog");
    end

    task automatic wait_clks(input int n);
        repeat (n) @(negedge clk);
    endtask

    task automatic load_tx(input logic [31:0] w);
        bit accepted;
        accepted = 1'b0;
        for (int i = 0; i < 20; i++) begin
            @(negedge clk);
            if (bus.o_tx_ready) begin
                bus.i_tx_data  = w;
                bus.i_tx_valid = 1'b1;
                @(negedge clk);
                bus.i_tx_valid = 1'b0;
                accepted = 1'b1;
                break;
            end
        end
        total++;
        if (!accepted) begin
            bad++;
            $display("FAIL load_tx: buffer never ready got=0 required=1");
        end
    endtask

    // The master shifts MOSI after each fall and samples MISO just before each rise.
    task automatic spi_shift(input logic [31:0] mw, input int len, input int nsend,
                             input logic lsb, output logic [31:0] sw);
        sw = '0;
        for (int i = 0; i < nsend; i++) begin
            int idx;
            idx = lsb ? i : (len - 1 - i);
            bus.i_mosi = mw[idx];
            wait_clks(8);
            sw[idx] = bus.o_miso;
            bus.i_sclk = 1'b1;
            wait_clks(8);
            bus.i_sclk = 1'b0;
        end
        wait_clks(8);
    endtask

    task automatic test_reset;
        total++; if (bus.o_miso !== 1'b0)     begin bad++; $display("FAIL reset_miso got=%b required=0", bus.o_miso); end
        total++; if (bus.o_miso_oe !== 1'b0)  begin bad++; $display("FAIL reset_oe got=%b required=0", bus.o_miso_oe); end
        total++; if (bus.o_tip !== 1'b0)      begin bad++; $display("FAIL reset_tip got=%b required=0", bus.o_tip); end
        total++; if (bus.o_tx_ready !== 1'b1) begin bad++; $display("FAIL reset_ready got=%b required=1", bus.o_tx_ready); end
        total++; if (bus.o_rx_data !== 32'h0) begin bad++; $display("FAIL reset_rx_data got=%h required=0", bus.o_rx_data); end
        total++; if ({bus.o_rx_valid, bus.o_underrun, bus.o_abort} !== 3'b000)
            begin bad++; $display("FAIL reset_pulses got=%b required=000", {bus.o_rx_valid, bus.o_underrun, bus.o_abort}); end
    endtask

    task automatic test_msb_first;
        logic [31:0] sw;
        int rx0, ab0;
        rx0 = rx_pulses; ab0 = ab_pulses;
        bus.i_len = 5'd8; bus.i_lsb = 1'b0;
        load_tx(32'hA5);
        total++; if (bus.o_tx_ready !== 1'b0) begin bad++; $display("FAIL msb_ready_full got=%b required=0", bus.o_tx_ready); end
        @(negedge clk);
        bus.i_ss_n = 1'b0;
        wait_clks(3);
        total++; if (bus.o_miso_oe !== 1'b0) begin bad++; $display("FAIL msb_oe_early got=%b required=0", bus.o_miso_oe); end
        @(negedge clk);
        total++; if (bus.o_miso_oe !== 1'b1) begin bad++; $display("FAIL msb_oe_at4 got=%b required=1", bus.o_miso_oe); end
        total++; if (bus.o_miso !== 1'b1)    begin bad++; $display("FAIL msb_first_bit got=%b required=1", bus.o_miso); end
        total++; if (bus.o_tip !== 1'b1)     begin bad++; $display("FAIL msb_tip got=%b required=1", bus.o_tip); end
        total++; if (bus.o_tx_ready !== 1'b1) begin bad++; $display("FAIL msb_ready_after_load got=%b required=1", bus.o_tx_ready); end
        wait_clks(4);
        spi_shift(32'h3C, 8, 8, 1'b0, sw);
        total++; if (sw !== 32'hA5)            begin bad++; $display("FAIL msb_miso_word got=%h required=a5", sw); end
        total++; if (rx_pulses - rx0 !== 1)    begin bad++; $display("FAIL msb_rx_valid_count got=%0d required=1", rx_pulses - rx0); end
        total++; if (bus.o_rx_data !== 32'h3C) begin bad++; $display("FAIL msb_rx_data got=%h required=3c", bus.o_rx_data); end
        bus.i_ss_n = 1'b1;
        wait_clks(8);
        total++; if ({bus.o_tip, bus.o_miso_oe} !== 2'b00) begin bad++; $display("FAIL msb_idle got=%b required=00", {bus.o_tip, bus.o_miso_oe}); end
        total++; if (ab_pulses - ab0 !== 0)    begin bad++; $display("FAIL msb_no_abort got=%0d required=0", ab_pulses - ab0); end
    endtask

    task automatic test_lsb_first;
        logic [31:0] sw;
        int rx0;
        rx0 = rx_pulses;
        bus.i_len = 5'd8; bus.i_lsb = 1'b1;
        load_tx(32'hA5);
        bus.i_ss_n = 1'b0;
        wait_clks(8);
        total++; if (bus.o_miso !== 1'b1) begin bad++; $display("FAIL lsb_first_bit got=%b required=1", bus.o_miso); end
        spi_shift(32'h01, 8, 8, 1'b1, sw);
        total++; if (sw !== 32'hA5)            begin bad++; $display("FAIL lsb_miso_word got=%h required=a5", sw); end
        total++; if (rx_pulses - rx0 !== 1)    begin bad++; $display("FAIL lsb_rx_valid_count got=%0d required=1", rx_pulses - rx0); end
        total++; if (bus.o_rx_data !== 32'h01) begin bad++; $display("FAIL lsb_rx_data got=%h required=01", bus.o_rx_data); end
        bus.i_ss_n = 1'b1;
        bus.i_lsb  = 1'b0;
        wait_clks(8);
    endtask

    task automatic test_back_to_back;
        logic [31:0] sw1, sw2;
        int rx0;
        rx0 = rx_pulses;
        bus.i_len = 5'd0;
        load_tx(32'hDEADBEEF);
        bus.i_ss_n = 1'b0;
        wait_clks(8);
        load_tx(32'h12345678);
        spi_shift(32'hCAFEF00D, 32, 32, 1'b0, sw1);
        spi_shift(32'h0F1E2D3C, 32, 32, 1'b0, sw2);
        total++; if (sw1 !== 32'hDEADBEEF)   begin bad++; $display("FAIL b2b_miso1 got=%h required=deadbeef", sw1); end
        total++; if (sw2 !== 32'h12345678)   begin bad++; $display("FAIL b2b_miso2 got=%h required=12345678", sw2); end
        total++; if (rx_pulses - rx0 !== 2)  begin bad++; $display("FAIL b2b_rx_valid_count got=%0d required=2", rx_pulses - rx0); end
        total++; if (rx_hist[rx0 % 16] !== 32'hCAFEF00D)
            begin bad++; $display("FAIL b2b_rx1 got=%h required=cafef00d", rx_hist[rx0 % 16]); end
        total++; if (bus.o_rx_data !== 32'h0F1E2D3C)
            begin bad++; $display("FAIL b2b_rx2 got=%h required=0f1e2d3c", bus.o_rx_data); end
        bus.i_ss_n = 1'b1;
        bus.i_len  = 5'd8;
        wait_clks(8);
    endtask

    task automatic test_underrun;
        logic [31:0] sw;
        int ur0;
        total++; if (bus.o_tx_ready !== 1'b1) begin bad++; $display("FAIL ur_buffer_empty got=%b required=1", bus.o_tx_ready); end
        ur0 = ur_pulses;
        bus.i_ss_n = 1'b0;
        wait_clks(8);
        total++; if (ur_pulses - ur0 !== 1) begin bad++; $display("FAIL ur_pulse_count got=%0d required=1", ur_pulses - ur0); end
        spi_shift(32'h96, 8, 8, 1'b0, sw);
        total++; if (sw !== 32'h0)             begin bad++; $display("FAIL ur_miso_zero got=%h required=0", sw); end
        total++; if (bus.o_rx_data !== 32'h96) begin bad++; $display("FAIL ur_rx_data got=%h required=96", bus.o_rx_data); end
        bus.i_ss_n = 1'b1;
        wait_clks(8);
    endtask

    task automatic test_abort;
        logic [31:0] sw;
        int rx0, ab0;
        load_tx(32'h5A);
        rx0 = rx_pulses; ab0 = ab_pulses;
        bus.i_ss_n = 1'b0;
        wait_clks(8);
        spi_shift(32'hFF, 8, 3, 1'b0, sw);
        total++; if (sw !== 32'h40) begin bad++; $display("FAIL abort_partial_miso got=%h required=40", sw); end
        bus.i_ss_n = 1'b1;
        wait_clks(8);
        total++; if (ab_pulses - ab0 !== 1)    begin bad++; $display("FAIL abort_pulse_count got=%0d required=1", ab_pulses - ab0); end
        total++; if (rx_pulses - rx0 !== 0)    begin bad++; $display("FAIL abort_no_rx_valid got=%0d required=0", rx_pulses - rx0); end
        total++; if (bus.o_rx_data !== 32'h96) begin bad++; $display("FAIL abort_rx_held got=%h required=96", bus.o_rx_data); end
        total++; if (bus.o_tip !== 1'b0)       begin bad++; $display("FAIL abort_tip got=%b required=0", bus.o_tip); end
        load_tx(32'hC3);
        bus.i_ss_n = 1'b0;
        wait_clks(8);
        spi_shift(32'h81, 8, 8, 1'b0, sw);
        total++; if (sw !== 32'hC3)            begin bad++; $display("FAIL abort_next_miso got=%h required=c3", sw); end
        total++; if (bus.o_rx_data !== 32'h81) begin bad++; $display("FAIL abort_next_rx got=%h required=81", bus.o_rx_data); end
        bus.i_ss_n = 1'b1;
        wait_clks(8);
    endtask

    task automatic test_reset_mid;
        logic [31:0] sw;
        int ab0;
        ab0 = ab_pulses;
        load_tx(32'h77);
        bus.i_ss_n = 1'b0;
        wait_clks(8);
        spi_shift(32'h55, 8, 4, 1'b0, sw);
        rst_n = 1'b0;
        @(negedge clk);
        total++; if ({bus.o_tip, bus.o_miso_oe, bus.o_miso} !== 3'b000)
            begin bad++; $display("FAIL rstmid_outputs got=%b required=000", {bus.o_tip, bus.o_miso_oe, bus.o_miso}); end
        total++; if (bus.o_tx_ready !== 1'b1)  begin bad++; $display("FAIL rstmid_ready got=%b required=1", bus.o_tx_ready); end
        total++; if (bus.o_rx_data !== 32'h0)  begin bad++; $display("FAIL rstmid_rx_data got=%h required=0", bus.o_rx_data); end
        bus.i_ss_n = 1'b1;
        wait_clks(3);
        rst_n = 1'b1;
        wait_clks(8);
        total++; if (ab_pulses - ab0 !== 0)    begin bad++; $display("FAIL rstmid_no_abort got=%0d required=0", ab_pulses - ab0); end
        load_tx(32'h3C);
        bus.i_ss_n = 1'b0;
        wait_clks(8);
        spi_shift(32'hA5, 8, 8, 1'b0, sw);
        total++; if (sw !== 32'h3C)            begin bad++; $display("FAIL rstmid_next_miso got=%h required=3c", sw); end
        total++; if (bus.o_rx_data !== 32'hA5) begin bad++; $display("FAIL rstmid_next_rx got=%h required=a5", bus.o_rx_data); end
        bus.i_ss_n = 1'b1;
        wait_clks(8);
    endtask

    initial begin
        rst_n            = 1'b0;
        bus.i_sclk       = 1'b0;
        bus.i_ss_n       = 1'b1;
        bus.i_mosi       = 1'b0;
        bus.i_len        = 5'd8;
        bus.i_lsb        = 1'b0;
        bus.i_rx_negedge = 1'b0;
        bus.i_tx_negedge = 1'b1;
        bus.i_tx_data    = '0;
        bus.i_tx_valid   = 1'b0;
        wait_clks(4);
        rst_n = 1'b1;
        @(negedge clk);

        test_reset;
        test_msb_first;
        test_lsb_first;
        test_back_to_back;
        test_underrun;
        test_abort;
        test_reset_mid;

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule
